serial_word_adder: RTL
======================

// Module: serial_word_adder
// PURPOSE
//  Bit-serial adder built around the half/full-adder primitive. It consumes two
//  operands LSB-first, one bit pair per accepted cycle, and keeps the carry in a register.
//  It emits each sum bit serially and assembles the WIDTH-bit sum word plus carry-out.
//  The block sits directly downstream of a serialiser and feeds word-level consumers.
// PARAMETERS
//  WIDTH  8  operand/sum word length in bits (>=2)
// PORTS
//  clk        in   1      single clock, all state updates on posedge
//  areset     in   1      asynchronous reset, active-high
//  start      in   1      begin a new word: clear carry, count, sum_word
//  in_valid   in   1      a/b carry a valid bit pair this cycle
//  a          in   1      operand A bit (LSB first)
//  b          in   1      operand B bit (LSB first)
//  sum_bit    out  1      registered serial sum bit
//  sum_valid  out  1      sum_bit valid (1-cycle pulse per accepted pair)
//  sum_word   out  WIDTH  assembled sum, bit i = i-th accepted sum bit
//  cout       out  1      carry out of MSB, valid when done=1
//  done       out  1      1-cycle pulse: sum_word/cout final
//  busy       out  1      1 while in ADD state
// BEHAVIOUR
//  Reset: state=IDLE, carry=0, count=0. All outputs are 0:
//   sum_bit, sum_valid, sum_word, cout, done, busy.
//  FSM states IDLE, ADD, DONE; registered, one-hot or binary.
//  IDLE: busy=0. in_valid is ignored. start=1 -> ADD, with carry<=0, count<=0, sum_word<=0.
//   start only arms; the pair on a start cycle is NOT consumed.
//  ADD: busy=1. On in_valid=1 with start=0:
//   s = a^b^carry; carry <= (a&b)|(a&carry)|(b&carry).
//   sum_word[count] <= s; sum_bit <= s; sum_valid <= 1; count <= count+1.
//   Latency: sum_bit/sum_valid appear 1 cycle after the pair is accepted.
//  in_valid=0 in ADD: stall. carry, count and sum_word hold; sum_valid=0.
//  Last pair (count==WIDTH-1 && in_valid): cout <= final carry-out; next state DONE.
//  DONE: done=1 for exactly one cycle. busy=0. Next state IDLE unless start=1.
//   start=1 in DONE -> ADD (back-to-back words, no idle cycle).
//  sum_word and cout hold their final values until the next start is accepted.
//   start clears both.
//  start=1 in ADD (simultaneous with in_valid or not): abort the current word.
//   carry, count and sum_word clear; the pair is not consumed; stay in ADD; no done pulse.
//  count is wide enough for 0..WIDTH-1 and never wraps past WIDTH-1.
//  The ADD->DONE transition is the only exit from ADD.
//  areset mid-word: immediate return to the reset values; the partial word is lost.
//  Result: {cout,sum_word} == A+B modulo 2^(WIDTH+1), i.e. the exact sum.
// TESTING
//  1) start, then 8 pairs of A=8'h3C, B=8'h05, no stalls
//     -> done at cycle 9 after start, sum_word=8'h41, cout=0.
//  2) A=8'hFF, B=8'h01 -> sum_word=8'h00, cout=1.
//     sum_bit stream LSB-first = 0,0,0,0,0,0,0,0.
//  3) A=8'hA5, B=8'h5A with in_valid low for 3 cycles after bit 2
//     -> sum_word=8'hFF, cout=0; done is delayed exactly 3 cycles.
//  4) start mid-word after 4 bits, then full A=8'h80, B=8'h80
//     -> no done for the aborted word; sum_word=8'h00, cout=1.
//  5) areset asserted after 5 bits -> all outputs 0 the same cycle, state IDLE.
//     A following word 8'h12+8'h34 gives 8'h46.
//  6) start in the DONE cycle, back-to-back with random A/B for 100 words
//     -> every {cout,sum_word} matches A+B; sum_valid count = 8 per word.

Source files
------------

// File: rtl/serial_word_adder_if.sv
// Word-level handshake bundle between the serialiser side and the bit-serial adder.
interface serial_word_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             in_valid;
  logic             a;
  logic             b;
  logic             sum_bit;
  logic             sum_valid;
  logic [WIDTH-1:0] sum_word;
  logic             cout;
  logic             done;
  logic             busy;

  // Upstream side: drives operand bits and start, observes the result.
  modport master (
    output start, in_valid, a, b,
    input  sum_bit, sum_valid, sum_word, cout, done, busy
  );

  // Adder side.
  modport slave (
    input  start, in_valid, a, b,
    output sum_bit, sum_valid, sum_word, cout, done, busy
  );
endinterface

// File: rtl/serial_word_adder.sv
// Bit-serial adder: one LSB-first bit pair per accepted cycle, carry kept in a
// register, sum bits streamed out and assembled into a WIDTH-bit word plus cout.
module serial_word_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk,
  input logic              areset,
  serial_word_adder_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic             carry;
  logic [CNT_W-1:0] count;
  logic             sum_bit_reg;
  logic             sum_valid_reg;
  logic [WIDTH-1:0] sum_word_reg;
  logic             cout_reg;
  logic             done_reg;
  logic             busy_reg;

  logic sum_c;
  logic carry_c;

  // Full-adder primitive on the current pair and the stored carry.
  assign sum_c   = bus.a ^ bus.b ^ carry;
  assign carry_c = (bus.a & bus.b) | (bus.a & carry) | (bus.b & carry);

  // Control FSM plus datapath registers; start arms from any state and
  // discards the pair presented with it.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state         <= IDLE;
      carry         <= 1'b0;
      count         <= '0;
      sum_bit_reg   <= 1'b0;
      sum_valid_reg <= 1'b0;
      sum_word_reg  <= '0;
      cout_reg      <= 1'b0;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      sum_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= ADD;
            busy_reg     <= 1'b1;
            carry        <= 1'b0;
            count        <= '0;
            sum_word_reg <= '0;
            cout_reg     <= 1'b0;
          end
        end
        ADD: begin
          if (bus.start) begin
            carry        <= 1'b0;
            count        <= '0;
            sum_word_reg <= '0;
            cout_reg     <= 1'b0;
          end else if (bus.in_valid) begin
            carry               <= carry_c;
            sum_word_reg[count] <= sum_c;
            sum_bit_reg         <= sum_c;
            sum_valid_reg       <= 1'b1;
            if (count == LAST_IDX) begin
              cout_reg <= carry_c;
              done_reg <= 1'b1;
              busy_reg <= 1'b0;
              state    <= DONE;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (bus.start) begin
            state        <= ADD;
            busy_reg     <= 1'b1;
            carry        <= 1'b0;
            count        <= '0;
            sum_word_reg <= '0;
            cout_reg     <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sum_bit   = sum_bit_reg;
  assign bus.sum_valid = sum_valid_reg;
  assign bus.sum_word  = sum_word_reg;
  assign bus.cout      = cout_reg;
  assign bus.done      = done_reg;
  assign bus.busy      = busy_reg;

endmodule
